// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the serial SRAM port arbiter.
package sram_arb_pkg;

    localparam int SRAM_ADDR_WIDTH    = 17;
    localparam int SRAM_TIMEOUT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } sram_arb_state_t;

endpackage

// File: rtl/sram_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the port not served last wins.
module rr_pick2
    import sram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       grant
);

    always_comb begin
        valid = |req;
        grant = 1'b0;
        if (req == 2'b11) begin
            grant = ~last;
        end else begin
            grant = req[1];
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates the 8051 data path and audio DMA onto one SPI SRAM controller,
// one start/done transaction at a time, with a completion watchdog.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = SRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  sync_reset,
    input  logic [1:0]            req,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [1:0]            we,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic [1:0]            ack,
    output logic [1:0]            err,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  mem_start,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_done,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    localparam logic [SRAM_TIMEOUT_WIDTH-1:0] TIMEOUT_LAST =
        SRAM_TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    sram_arb_state_t               state;
    logic                          last;
    logic                          gnt;
    logic [SRAM_TIMEOUT_WIDTH-1:0] wait_cnt;
    logic                          pick_valid;
    logic                          pick_grant;

    rr_pick2 u_pick (
        .req   (req),
        .last  (last),
        .valid (pick_valid),
        .grant (pick_grant)
    );

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            gnt       <= 1'b0;
            wait_cnt  <= '0;
            ack       <= 2'b00;
            err       <= 2'b00;
            mem_start <= 1'b0;
            busy      <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            mem_start <= 1'b0;
            ack       <= 2'b00;
            err       <= 2'b00;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt       <= pick_grant;
                        mem_addr  <= pick_grant ? addr1 : addr0;
                        mem_we    <= we[pick_grant];
                        mem_wdata <= pick_grant ? wdata1 : wdata0;
                        mem_start <= 1'b1;
                        busy      <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // A done arriving on the timeout cycle still counts as success.
                    if (mem_done || (wait_cnt == TIMEOUT_LAST)) begin
                        state <= ACK;
                        ack   <= gnt ? 2'b10 : 2'b01;
                        err   <= mem_done ? 2'b00 : (gnt ? 2'b10 : 2'b01);
                        if (!mem_we) begin
                            if (gnt) begin
                                rdata1 <= mem_done ? mem_rdata : '0;
                            end else begin
                                rdata0 <= mem_done ? mem_rdata : '0;
                            end
                        end
                    end
                end
                ACK: begin
                    last  <= gnt;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed scoreboard bench for sram_port_arbiter with a scripted SRAM controller.
`timescale 1ns/1ps
module tb_sram_port_arbiter;

    localparam int AW = 17;
    localparam int DW = 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          sync_reset;
    logic [1:0]    req, we, ack, err;
    logic [AW-1:0] addr0, addr1, mem_addr;
    logic [DW-1:0] wdata0, wdata1, rdata0, rdata1, mem_wdata, mem_rdata;
    logic          mem_start, mem_we, mem_done, busy;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_starts = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
    } cmd_t;

    typedef struct {
        logic [1:0]    ack;
        logic [1:0]    err;
        logic [DW-1:0] rd0;
        logic [DW-1:0] rd1;
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    logic [DW-1:0] exp_rd0 = '0;
    logic [DW-1:0] exp_rd1 = '0;

    sram_port_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .req        (req),
        .addr0      (addr0),
        .addr1      (addr1),
        .we         (we),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .ack        (ack),
        .err        (err),
        .rdata0     (rdata0),
        .rdata1     (rdata1),
        .mem_start  (mem_start),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_done   (mem_done),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Command and completion scoreboards, sampled on the falling edge.
    always @(negedge clk) begin
        cmd_t c;
        rsp_t r;
        if (sync_reset === 1'b0) begin
            if (mem_start === 1'b1) begin
                n_starts++;
                if (cmd_q.size() == 0) begin
                    chk("cmd_unexpected", 32'(mem_start), 32'd0);
                end else begin
                    c = cmd_q.pop_front();
                    chk("cmd_addr", 32'(mem_addr), 32'(c.addr));
                    chk("cmd_we", 32'(mem_we), 32'(c.we));
                    chk("cmd_wdata", 32'(mem_wdata), 32'(c.wdata));
                end
            end
            if (ack !== 2'b00) begin
                if (rsp_q.size() == 0) begin
                    chk("ack_unexpected", 32'(ack), 32'd0);
                end else begin
                    r = rsp_q.pop_front();
                    chk("rsp_ack", 32'(ack), 32'(r.ack));
                    chk("rsp_err", 32'(err), 32'(r.err));
                    chk("rsp_rdata0", 32'(rdata0), 32'(r.rd0));
                    chk("rsp_rdata1", 32'(rdata1), 32'(r.rd1));
                end
            end else if (err !== 2'b00) begin
                chk("err_without_ack", 32'(err), 32'd0);
            end
        end
    end

    // One transaction on port p; dly<0 means the controller never answers.
    // drop: 0 keep req, 1 drop in the ack cycle, 2 drop right after mem_start.
    task automatic xact(input string tag, input logic p, input logic wr,
                        input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input int dly, input logic [DW-1:0] rd, input int drop,
                        output int start_cyc);
        cmd_t c;
        rsp_t r;
        int   k;
        if (p) begin
            addr1 = a; wdata1 = wd; we[1] = wr; req[1] = 1'b1;
        end else begin
            addr0 = a; wdata0 = wd; we[0] = wr; req[0] = 1'b1;
        end
        c.addr = a; c.we = wr; c.wdata = wd;
        cmd_q.push_back(c);
        if (!wr) begin
            if (p) exp_rd1 = (dly < 0) ? '0 : rd;
            else   exp_rd0 = (dly < 0) ? '0 : rd;
        end
        r.ack = p ? 2'b10 : 2'b01;
        r.err = (dly < 0) ? r.ack : 2'b00;
        r.rd0 = exp_rd0;
        r.rd1 = exp_rd1;
        rsp_q.push_back(r);

        k = 0;
        while (mem_start !== 1'b1 && k < 16) begin
            tick();
            k++;
        end
        start_cyc = cyc;
        chk({tag, "_start"}, 32'(mem_start), 32'd1);
        if (mem_start !== 1'b1) begin
            req[p] = 1'b0;
            cmd_q.delete();
            rsp_q.delete();
            return;
        end

        tick();
        chk({tag, "_start_pulse"}, 32'(mem_start), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        if (drop == 2) req[p] = 1'b0;
        if (dly < 0) begin
            mem_rdata = rd;
            repeat (TO - 1) tick();
            chk({tag, "_no_early_ack"}, 32'(ack), 32'd0);
            tick();
            mem_rdata = '0;
        end else begin
            repeat (dly - 1) tick();
            chk({tag, "_cmd_hold"}, 32'(mem_addr), 32'(a));
            chk({tag, "_no_early_ack"}, 32'(ack), 32'd0);
            mem_done  = 1'b1;
            mem_rdata = rd;
            tick();
            mem_done  = 1'b0;
            mem_rdata = '0;
        end
        chk({tag, "_ack"}, 32'(ack), 32'(r.ack));
        chk({tag, "_err"}, 32'(err), 32'(r.err));
        if (drop == 1) req[p] = 1'b0;
        tick();
        chk({tag, "_ack_pulse"}, 32'(ack), 32'd0);
        chk({tag, "_busy_clear"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int prev;
        int n0;
        int k;

        sync_reset = 1'b1;
        req = 2'b00; we = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        mem_done = 1'b0; mem_rdata = '0;
        repeat (3) tick();

        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_start", 32'(mem_start), 32'd0);
        chk("rst_rdata0", 32'(rdata0), 32'd0);
        chk("rst_rdata1", 32'(rdata1), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_we_wdata", 32'({mem_we, mem_wdata}), 32'd0);
        sync_reset = 1'b0;

        xact("p0_write", 1'b0, 1'b1, 17'h1_2345, 8'hA5, 5, 8'h00, 1, s);
        xact("p0_read", 1'b0, 1'b0, 17'h0_0200, 8'h00, 2, 8'h77, 2, s);
        xact("p1_read", 1'b1, 1'b0, 17'h0_0010, 8'h00, 3, 8'h3C, 1, s);
        chk("p1_read_rdata1_held", 32'(rdata1), 32'h3C);
        chk("p1_read_rdata0_kept", 32'(rdata0), 32'h77);

        // Both ports requesting continuously from reset.
        sync_reset = 1'b1;
        tick();
        tick();
        sync_reset = 1'b0;
        exp_rd0 = '0;
        exp_rd1 = '0;
        addr0 = 17'h0_1000; addr1 = 17'h0_2000;
        wdata0 = 8'h10; wdata1 = 8'h20;
        we = 2'b11;
        req = 2'b11;
        n0 = n_starts;
        prev = 0;
        for (int i = 0; i < 6; i++) begin
            xact("alt", i[0], 1'b1, (i[0] ? 17'h0_2000 : 17'h0_1000) + 17'(i),
                 8'(8'h10 + i), 1, 8'h00, (i >= 4) ? 1 : 0, s);
            if (i > 0) chk("alt_spacing", 32'(s - prev), 32'd4);
            prev = s;
        end
        chk("alt_start_count", 32'(n_starts - n0), 32'd6);

        // Watchdog abort, then normal service.
        xact("pre_to", 1'b0, 1'b0, 17'h0_0300, 8'h00, 2, 8'h99, 1, s);
        xact("timeout", 1'b0, 1'b0, 17'h1_FFFF, 8'h00, -1, 8'hEE, 1, s);
        chk("timeout_rdata0", 32'(rdata0), 32'd0);
        xact("after_to", 1'b1, 1'b1, 17'h0_0400, 8'h42, 2, 8'h00, 1, s);

        // Stray done while idle must be ignored.
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        repeat (3) tick();
        chk("stray_done_ack", 32'(ack), 32'd0);
        chk("stray_done_busy", 32'(busy), 32'd0);
        xact("done_at_to", 1'b1, 1'b0, 17'h0_0500, 8'h00, TO, 8'h5A, 1, s);

        // Reset while waiting on the controller.
        addr0 = 17'h0_0600; we[0] = 1'b0; req[0] = 1'b1;
        begin
            cmd_t c;
            c.addr = 17'h0_0600; c.we = 1'b0; c.wdata = wdata0;
            cmd_q.push_back(c);
        end
        k = 0;
        while (mem_start !== 1'b1 && k < 16) begin
            tick();
            k++;
        end
        chk("rst_wait_start", 32'(mem_start), 32'd1);
        tick();
        tick();
        chk("rst_wait_busy", 32'(busy), 32'd1);
        sync_reset = 1'b1;
        req[0] = 1'b0;
        tick();
        chk("rst_wait_busy_clear", 32'(busy), 32'd0);
        chk("rst_wait_ack", 32'(ack), 32'd0);
        chk("rst_wait_rdata0", 32'(rdata0), 32'd0);
        chk("rst_wait_rdata1", 32'(rdata1), 32'd0);
        chk("rst_wait_mem_addr", 32'(mem_addr), 32'd0);
        sync_reset = 1'b0;
        exp_rd0 = '0;
        exp_rd1 = '0;
        repeat (4) tick();
        chk("rst_wait_no_ack", 32'(ack), 32'd0);
        xact("post_reset_p1", 1'b1, 1'b0, 17'h0_0700, 8'h00, 2, 8'hC3, 1, s);

        repeat (3) tick();
        chk("cmd_q_empty", 32'(cmd_q.size()), 32'd0);
        chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-requester arbiter and sequencer for the shared M23XX1024 serial SRAM controller in the Mustang SoC. It shares the controller between the 8051 data-memory path (port 0) and the Si3000 audio DMA (port 1). Each request is serialized into a single start/done transaction on the controller's command interface, with round-robin fairness and a completion watchdog. It sits between the two requesters and the SPI SRAM engine that drives `mem_sck`/`mem_si`/`mem_cs_n`.

## Interface
Parameters:
- `ADDR_WIDTH`, default 17: byte address width (128 KB device).
- `DATA_WIDTH`, default 8: data byte width.
- `TIMEOUT_CYCLES`, default 1024: maximum cycles in WAIT before abort. Legal range 2..65535.

Ports:
- `clk`, in, 1: single system clock. All logic runs on its rising edge.
- `sync_reset`, in, 1: reset, synchronous and active-high.
- `req[1:0]`, in, 2: per-port request level. Held high, with fields stable, until `ack`.
- `addr0`/`addr1`, in, ADDR_WIDTH: request address.
- `we[1:0]`, in, 2: 1 = write, 0 = read.
- `wdata0`/`wdata1`, in, DATA_WIDTH: write data.
- `ack[1:0]`, out, 2: one-cycle completion pulse.
- `err[1:0]`, out, 2: one-cycle pulse coincident with `ack` when the transaction timed out.
- `rdata0`/`rdata1`, out, DATA_WIDTH: read data, valid in the `ack` cycle and held until that port's next `ack`.
- `mem_start`, out, 1: one-cycle command strobe to the SRAM controller.
- `mem_addr`, out, ADDR_WIDTH; `mem_we`, out, 1; `mem_wdata`, out, DATA_WIDTH: command fields. Stable from `mem_start` through `mem_done`.
- `mem_done`, in, 1: controller completion pulse.
- `mem_rdata`, in, DATA_WIDTH: valid with `mem_done`.
- `busy`, out, 1: high in any state other than IDLE.

## Operation
- FSM states and transitions:
  - IDLE → ISSUE when any `req` is set.
  - ISSUE → WAIT unconditionally.
  - WAIT → ACK on `mem_done` or on timeout.
  - ACK → IDLE unconditionally.
- Arbitration happens in IDLE only:
  - A single requester wins.
  - When both request, the port not granted last wins.
  - The `last` register resets to 1, so port 0 wins the first tie.
  - The grant index and all command fields are latched into registers on the IDLE→ISSUE edge.
- ISSUE: `mem_start`=1 for exactly one cycle.
- WAIT:
  - A 16-bit counter increments each cycle.
  - `mem_done` is sampled only in WAIT. A `mem_done` seen in ISSUE or IDLE is ignored.
  - Timeout: when the counter reaches TIMEOUT_CYCLES-1 without `mem_done`, go to ACK with the error flag set and `rdata` forced to 0.
  - `mem_done` and timeout in the same cycle: `mem_done` wins and no error is flagged.
- ACK:
  - Pulse `ack[g]`, plus `err[g]` if flagged.
  - Update `rdata_g` only on reads. Writes leave `rdata_g` unchanged.
  - Update `last` to g.
- A requester dropping `req` mid-transaction does not abort it. The transaction completes and `ack` is still pulsed.
- `sync_reset` mid-transaction: FSM returns to IDLE next cycle. No `ack` is generated for the in-flight request.

## Timing
- Reset values:
  - State IDLE; `ack`=0, `err`=0, `mem_start`=0, `busy`=0.
  - `rdata0`=`rdata1`=0; `mem_addr`/`mem_we`/`mem_wdata`=0.
  - `last`=1; counter 0.
- Latency:
  - Cycle N: `req` seen in IDLE.
  - Cycle N+1: `mem_start`.
  - Cycle M ≥ N+2: `mem_done`.
  - Cycle M+1: `ack`.
  - Cycle M+2: back in IDLE; a new grant is possible in that same cycle.
- Minimum transaction, with `mem_done` at N+2: 4 cycles from `req` to the next possible grant.
- `busy` is registered: high from N+1 through M+1.
- A `req` held high after `ack` is treated as a new request. Requesters must drop `req` in the cycle following `ack`.

## Structure
- Package `sram_arb_pkg`:
  - State enum `sram_arb_state_t` {IDLE, ISSUE, WAIT, ACK}.
  - Constants `SRAM_ADDR_WIDTH`=17, `SRAM_TIMEOUT_WIDTH`=16.
- One sub-module, `rr_pick2`: combinational 2-way round-robin picker with inputs `req[1:0]` and `last`, outputs `valid` and `grant`.
- The FSM, command registers, watchdog and `rdata` registers live in the top module.

## Test plan
- Port 0 write, `addr0`=17'h1_2345, `wdata0`=8'hA5, controller `mem_done` 5 cycles after `mem_start` → `mem_start` at N+1 with `mem_addr`=17'h1_2345, `mem_we`=1, `mem_wdata`=8'hA5; `ack[0]` exactly at `mem_done`+1; `err`=0.
- Port 1 read at 17'h0_0010, `mem_rdata`=8'h3C with `mem_done` → `ack[1]` pulse with `rdata1`=8'h3C; `rdata0` unchanged.
- Both `req` held continuously for 6 transactions from reset → grants alternate 0,1,0,1,0,1; exactly one `mem_start` per transaction.
- `mem_done` never asserted, TIMEOUT_CYCLES=8 → `ack[g]` and `err[g]` together 8 cycles after entering WAIT; `rdata_g`=0; next request serviced normally.
- `mem_done` pulsed during IDLE with no request, then `mem_done` on the timeout cycle → no `ack` from the stray pulse; the later transaction acks with `err`=0.
- `sync_reset` asserted in WAIT → next cycle `busy`=0, `ack`=0, `rdata` cleared; a fresh port 1 request with `last` reset is granted normally.
